// File: rtl/sending_buffer_pkg.sv
// Shared constants and FSM encoding for the sending_buffer operand gather block.
package sending_buffer_pkg;
    localparam int DATA_W     = 8;
    localparam int ADDR_W     = 6;
    localparam int LANES      = 8;
    localparam int ROW_STRIDE = 1;
    localparam int COL_STRIDE = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;
endpackage

// File: rtl/sending_buffer_addr_gen.sv
// Strided RAM address generator: latches base/stride on load, walks the lane index.
module sending_buffer_addr_gen #(
    parameter int ADDR_W = 6,
    parameter int LANES  = 8,
    parameter int IDX_W  = $clog2(LANES)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W-1:0] i_stride,
    input  logic              i_step,
    output logic [ADDR_W-1:0] o_addr,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_last
);
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_stride;
    logic [IDX_W-1:0]  r_idx;
    logic [ADDR_W-1:0] w_idx_ext;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_base   <= '0;
            r_stride <= '0;
            r_idx    <= '0;
        end else if (i_load) begin
            r_base   <= i_base;
            r_stride <= i_stride;
            r_idx    <= '0;
        end else if (i_step) begin
            r_idx    <= r_idx + 1'b1;
        end
    end

    // Truncation to ADDR_W bits gives the silent modulo-64 wrap.
    assign w_idx_ext = ADDR_W'(r_idx);
    assign o_addr    = i_step ? (r_base + w_idx_ext * r_stride) : '0;
    assign o_idx     = r_idx;
    assign o_last    = (r_idx == IDX_W'(LANES - 1));
endmodule

// File: rtl/sending_buffer.sv
// Gathers LANES strided operands from serial RAM into one parallel word (valid/ready).
// Optional registered lane sum on out_sum when SENDING_BUFFER_SUM_EN is defined.
module sending_buffer
    import sending_buffer_pkg::*;
#(
    parameter int DATA_W = sending_buffer_pkg::DATA_W,
    parameter int ADDR_W = sending_buffer_pkg::ADDR_W,
    parameter int LANES  = sending_buffer_pkg::LANES
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [ADDR_W-1:0]         stride,
    output logic                      busy,
    output logic                      rd_en,
    output logic [ADDR_W-1:0]         rd_addr,
    input  logic [DATA_W-1:0]         rd_data,
    output logic [LANES*DATA_W-1:0]   out_lanes,
    output logic                      out_valid,
    input  logic                      out_ready
`ifdef SENDING_BUFFER_SUM_EN
    ,
    output logic signed [DATA_W+3:0]  out_sum
`endif
);
    localparam int IDX_W = $clog2(LANES);

    state_t                        r_state;
    state_t                        w_next;
    logic [IDX_W-1:0]              w_idx;
    logic                          w_last;
    logic                          w_fetch;
    logic                          r_cap_en;
    logic [IDX_W-1:0]              r_cap_idx;
    logic [LANES-1:0][DATA_W-1:0]  r_lanes;

    assign w_fetch = (r_state == FETCH);

    sending_buffer_addr_gen #(
        .ADDR_W (ADDR_W),
        .LANES  (LANES),
        .IDX_W  (IDX_W)
    ) u_addr_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_load   ((r_state == IDLE) && start),
        .i_base   (base_addr),
        .i_stride (stride),
        .i_step   (w_fetch),
        .o_addr   (rd_addr),
        .o_idx    (w_idx),
        .o_last   (w_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (start)     w_next = FETCH;
            FETCH: if (w_last)    w_next = DRAIN;
            DRAIN:                w_next = HOLD;
            HOLD:  if (out_ready) w_next = IDLE;
            default:              w_next = IDLE;
        endcase
    end

    assign busy      = (r_state != IDLE);
    assign rd_en     = w_fetch;
    assign out_valid = (r_state == HOLD);
    assign out_lanes = r_lanes;

    // RAM data lags the strobe by one cycle, so capture uses the index delayed alongside it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cap_en  <= 1'b0;
            r_cap_idx <= '0;
            r_lanes   <= '0;
        end else begin
            r_cap_en  <= w_fetch;
            r_cap_idx <= w_idx;
            if (r_cap_en) r_lanes[r_cap_idx] <= rd_data;
        end
    end

`ifdef SENDING_BUFFER_SUM_EN
    logic [DATA_W+3:0] r_sum;
    logic [DATA_W+3:0] w_rd_sext;

    assign w_rd_sext = {{4{rd_data[DATA_W-1]}}, rd_data};

    // Running sum restarts on lane 0 and is complete once the last lane lands in DRAIN.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      r_sum <= '0;
        else if (r_cap_en) r_sum <= ((r_cap_idx == '0) ? '0 : r_sum) + w_rd_sext;
    end

    assign out_sum = $signed(r_sum);
`endif
endmodule

// File: tb/tb_sending_buffer.sv
// Self-checking bench for sending_buffer: randomized RAM contents vs a strided-gather model.
module tb_sending_buffer;
    import sending_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [5:0]  base_addr;
    logic [5:0]  stride;
    logic        busy;
    logic        rd_en;
    logic [5:0]  rd_addr;
    logic [7:0]  rd_data;
    logic [63:0] out_lanes;
    logic        out_valid;
    logic        out_ready;
`ifdef SENDING_BUFFER_SUM_EN
    logic signed [11:0] out_sum;
`endif

    logic [7:0] ram [64];
    int checks   = 0;
    int failures = 0;

    sending_buffer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .stride    (stride),
        .busy      (busy),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_lanes (out_lanes),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef SENDING_BUFFER_SUM_EN
        ,
        .out_sum   (out_sum)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous RAM: data one cycle after the strobe.
    always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

    // Expected word: lane k = RAM[(base + k*stride) mod 64].
    function automatic logic [63:0] model_lanes(input logic [5:0] b, input logic [5:0] s);
        logic [63:0] w;
        logic [5:0]  a;
        for (int k = 0; k < 8; k++) begin
            a = 6'(int'(b) + k * int'(s));
            w[k*8 +: 8] = ram[a];
        end
        return w;
    endfunction

    function automatic int model_sum(input logic [5:0] b, input logic [5:0] s);
        int acc = 0;
        logic [5:0] a;
        for (int k = 0; k < 8; k++) begin
            a = 6'(int'(b) + k * int'(s));
            acc += int'($signed(ram[a]));
        end
        return acc;
    endfunction

    // Runs one transaction from a negedge in cycle 0; returns at the negedge of cycle 10.
    task automatic fetch_txn(input logic [5:0] b, input logic [5:0] s, input int ign_cyc, input string tag);
        logic [5:0]  ea;
        logic [63:0] el;
        start = 1'b1; base_addr = b; stride = s;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            ea = 6'(int'(b) + (c - 1) * int'(s));
            checks++;
            if (rd_en !== 1'b1 || rd_addr !== ea || busy !== 1'b1 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL %s fetch c%0d: rd_en=%b rd_addr=%0d busy=%b valid=%b, want 1 %0d 1 0",
                         tag, c, rd_en, rd_addr, busy, out_valid, ea);
            end
            if (c == ign_cyc) begin start = 1'b1; base_addr = ~b; stride = s + 6'd3; end
            @(negedge clk);
            start = 1'b0;
        end
        checks++;
        if (rd_en !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s drain: rd_en=%b busy=%b valid=%b, want 0 1 0", tag, rd_en, busy, out_valid);
        end
        @(negedge clk);
        el = model_lanes(b, s);
        checks++;
        if (out_valid !== 1'b1 || out_lanes !== el) begin
            failures++;
            $display("FAIL %s word: valid=%b lanes=%h, want 1 %h", tag, out_valid, out_lanes, el);
        end
`ifdef SENDING_BUFFER_SUM_EN
        checks++;
        if (out_sum !== 12'(model_sum(b, s))) begin
            failures++;
            $display("FAIL %s sum: got %0d want %0d", tag, out_sum, model_sum(b, s));
        end
`endif
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0) begin
            failures++;
            $display("FAIL %s handshake: valid=%b busy=%b rd_en=%b, want 0 0 0", tag, out_valid, busy, rd_en);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 64; i++) ram[i] = 8'($urandom);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; out_ready = 1'b0; base_addr = '0; stride = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rd_en !== 1'b0 || rd_addr !== 6'd0 || out_lanes !== 64'd0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset: busy=%b rd_en=%b addr=%0d lanes=%h valid=%b, want all 0",
                     busy, rd_en, rd_addr, out_lanes, out_valid);
        end
`ifdef SENDING_BUFFER_SUM_EN
        checks++;
        if (out_sum !== 12'sd0) begin failures++; $display("FAIL reset sum: got %0d want 0", out_sum); end
`endif
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset idle: busy=%b want 0", busy); end
    endtask

    task automatic test_row();
        for (int i = 0; i < 64; i++) ram[i] = 8'(i - 3);
        fetch_txn(6'd8, 6'(ROW_STRIDE), 0, "row");
        checks++;
        if (out_lanes[7:0] !== 8'd5 || out_lanes[63:56] !== 8'd12) begin
            failures++;
            $display("FAIL row ends: lane0=%0d lane7=%0d want 5 12", out_lanes[7:0], out_lanes[63:56]);
        end
`ifdef SENDING_BUFFER_SUM_EN
        checks++;
        if (out_sum !== 12'sd68) begin failures++; $display("FAIL row sum: got %0d want 68", out_sum); end
`endif
        handshake("row");
    endtask

    task automatic test_col_wrap();
        fill_random();
        fetch_txn(6'd56, 6'(COL_STRIDE), 0, "colwrap");
        handshake("colwrap");
    endtask

    task automatic test_backpressure();
        logic [63:0] el;
        fill_random();
        fetch_txn(6'(3), 6'(5), 0, "bp");
        el = model_lanes(6'd3, 6'd5);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || rd_en !== 1'b0 || out_lanes !== el) begin
                failures++;
                $display("FAIL bp hold %0d: valid=%b busy=%b rd_en=%b lanes=%h want 1 1 0 %h",
                         i, out_valid, busy, rd_en, out_lanes, el);
            end
        end
        handshake("bp");
    endtask

    task automatic test_start_ignored();
        logic [63:0] el;
        fill_random();
        fetch_txn(6'd20, 6'd7, 3, "ign");
        el = model_lanes(6'd20, 6'd7);
        @(negedge clk);                        // cycle 11
        @(negedge clk);                        // cycle 12
        start = 1'b1; base_addr = 6'd1; stride = 6'd1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_en !== 1'b0 || out_valid !== 1'b1 || out_lanes !== el) begin
                failures++;
                $display("FAIL ign hold %0d: rd_en=%b valid=%b lanes=%h want 0 1 %h", i, rd_en, out_valid, out_lanes, el);
            end
            @(negedge clk);
        end
        handshake("ign");
    endtask

    task automatic test_reset_mid();
        fill_random();
        start = 1'b1; base_addr = 6'd10; stride = 6'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);             // negedge of cycle 4
        reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || rd_en !== 1'b0 || rd_addr !== 6'd0 || out_lanes !== 64'd0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset: busy=%b rd_en=%b addr=%0d lanes=%h valid=%b, want all 0",
                     busy, rd_en, rd_addr, out_lanes, out_valid);
        end
`ifdef SENDING_BUFFER_SUM_EN
        checks++;
        if (out_sum !== 12'sd0) begin failures++; $display("FAIL midreset sum: got %0d want 0", out_sum); end
`endif
        #2 reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rd_en !== 1'b0) begin
            failures++;
            $display("FAIL midreset idle: busy=%b rd_en=%b want 0 0", busy, rd_en);
        end
        fetch_txn(6'($urandom), 6'($urandom), 0, "after_reset");
        handshake("after_reset");
    endtask

    task automatic test_neg_extreme();
        for (int i = 0; i < 64; i++) ram[i] = 8'h80;
        fetch_txn(6'($urandom), 6'd0, 0, "neg");
        checks++;
        if (out_lanes !== {8{8'h80}}) begin
            failures++;
            $display("FAIL neg lanes: got %h want all 80", out_lanes);
        end
`ifdef SENDING_BUFFER_SUM_EN
        checks++;
        if (out_sum !== -12'sd1024) begin failures++; $display("FAIL neg sum: got %0d want -1024", out_sum); end
`endif
        handshake("neg");
    endtask

    task automatic test_back_to_back();
        logic [5:0] b, s;
        for (int t = 0; t < 8; t++) begin
            fill_random();
            b = 6'($urandom);
            case (t % 4)
                0: s = 6'(ROW_STRIDE);
                1: s = 6'(COL_STRIDE);
                default: s = 6'($urandom);
            endcase
            fetch_txn(b, s, 0, "b2b");
            repeat ($urandom_range(0, 2)) @(negedge clk);
            handshake("b2b");
        end
    endtask

    initial begin
        test_reset();
        test_row();
        test_col_wrap();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        test_neg_extreme();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
